// File: rtl/encoder4_2_hs.sv
// rtl/encoder4_2_hs.sv - registered 4-to-2 encoder behind a 1-entry valid/ready buffer
// Define ENC_ERR_CNT_EN to build the saturating err_cnt; otherwise err_cnt is tied to 0.
module encoder4_2_hs #(
    parameter int CNT_W   = 8,
    parameter int HI_PRIO = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       code,
    output logic             code_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic       err_q, err_d;
    logic [1:0] enc_code;
    logic       enc_err;
    logic       accept;

    assign in_ready = (state_q == EMPTY) | out_ready;
    assign accept   = in_valid & in_ready;

    // Zero-hot and multi-hot both flag an error; the priority direction only picks the code.
    always_comb begin
        enc_code = 2'b00;
        enc_err  = (in == 4'b0000) | ((in & (in - 4'd1)) != 4'b0000);
        if (HI_PRIO != 0) begin
            for (int k = 0; k < 4; k++)
                if (in[k]) enc_code = k[1:0];
        end else begin
            for (int k = 3; k >= 0; k--)
                if (in[k]) enc_code = k[1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        err_d   = err_q;
        if (accept) begin
            code_d = enc_code;
            err_d  = enc_err;
        end
        case (state_q)
            EMPTY:   if (in_valid) state_d = FULL;
            FULL:    if (out_ready && !in_valid) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            code_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign code      = code_q;
    assign code_err  = err_q;

`ifdef ENC_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && enc_err && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_encoder4_2_hs.sv
// tb/tb_encoder4_2_hs.sv - directed vector bench for encoder4_2_hs
module tb_encoder4_2_hs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       req_valid;
    logic       out_ready;

    logic       in_ready,  in_ready_lo;
    logic [1:0] code,      code_lo;
    logic       code_err,  code_err_lo;
    logic       out_valid, out_valid_lo;
    logic [1:0] err_cnt;
    logic [7:0] err_cnt_lo;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    encoder4_2_hs #(.CNT_W(2), .HI_PRIO(1)) dut (
        .clk(clk), .rst_n(rst_n), .in(req), .in_valid(req_valid), .in_ready(in_ready),
        .code(code), .code_err(code_err), .out_valid(out_valid), .out_ready(out_ready),
        .err_cnt(err_cnt)
    );

    encoder4_2_hs #(.CNT_W(8), .HI_PRIO(0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .in(req), .in_valid(req_valid), .in_ready(in_ready_lo),
        .code(code_lo), .code_err(code_err_lo), .out_valid(out_valid_lo), .out_ready(out_ready),
        .err_cnt(err_cnt_lo)
    );

    typedef struct {
        logic [3:0] req;
        logic       vld;
        logic       ordy;
        logic       exp_rdy;
        logic       exp_ovld;
        logic [1:0] exp_code;
        logic       exp_err;
        logic [1:0] exp_code_lo;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] cnt_exp(input logic [1:0] c);
`ifdef ENC_ERR_CNT_EN
        return c;
`else
        return 2'd0;
`endif
    endfunction

    task automatic add(input logic [3:0] r, input logic v, input logic o, input logic rdy,
                       input logic ov, input logic [1:0] c, input logic e,
                       input logic [1:0] clo, input logic [1:0] cnt);
        vec_t t;
        t = '{req: r, vld: v, ordy: o, exp_rdy: rdy, exp_ovld: ov, exp_code: c,
              exp_err: e, exp_code_lo: clo, exp_cnt: cnt};
        tbl.push_back(t);
    endtask

    initial begin
        // one-hot sweep, full throughput
        add(4'b0001, 1, 1, 1, 1, 2'd0, 0, 2'd0, 2'd0);
        add(4'b0010, 1, 1, 1, 1, 2'd1, 0, 2'd1, 2'd0);
        add(4'b0100, 1, 1, 1, 1, 2'd2, 0, 2'd2, 2'd0);
        add(4'b1000, 1, 1, 1, 1, 2'd3, 0, 2'd3, 2'd0);
        // backpressure: code 2 held for 3 clks, then code 3
        add(4'b0100, 1, 1, 1, 1, 2'd2, 0, 2'd2, 2'd0);
        add(4'b1000, 1, 0, 0, 1, 2'd2, 0, 2'd2, 2'd0);
        add(4'b1000, 1, 0, 0, 1, 2'd2, 0, 2'd2, 2'd0);
        add(4'b1000, 1, 0, 0, 1, 2'd2, 0, 2'd2, 2'd0);
        add(4'b1000, 1, 1, 1, 1, 2'd3, 0, 2'd3, 2'd0);
        // error inputs; counter saturates at 3
        add(4'b0000, 1, 1, 1, 1, 2'd0, 1, 2'd0, 2'd1);
        add(4'b0110, 1, 1, 1, 1, 2'd2, 1, 2'd1, 2'd2);
        add(4'b1111, 1, 1, 1, 1, 2'd3, 1, 2'd0, 2'd3);
        add(4'b1001, 1, 1, 1, 1, 2'd3, 1, 2'd0, 2'd3);
        add(4'b0011, 1, 1, 1, 1, 2'd1, 1, 2'd0, 2'd3);
        // drain: single accept then idle
        add(4'b0001, 1, 1, 1, 1, 2'd0, 0, 2'd0, 2'd3);
        add(4'b0000, 0, 1, 1, 0, 2'd0, 0, 2'd0, 2'd3);
        add(4'b0000, 0, 0, 1, 0, 2'd0, 0, 2'd0, 2'd3);

        rst_n = 1'b0; req = 4'b0000; req_valid = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_code",      32'(code), 0);
        chk("rst_code_err",  32'(code_err), 0);
        chk("rst_err_cnt",   32'(err_cnt), 0);
        chk("rst_in_ready",  32'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req; req_valid = tbl[i].vld; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ovld));
            chk($sformatf("v%0d_code", i),      32'(code),      32'(tbl[i].exp_code));
            chk($sformatf("v%0d_code_err", i),  32'(code_err),  32'(tbl[i].exp_err));
            chk($sformatf("v%0d_code_lo", i),   32'(code_lo),   32'(tbl[i].exp_code_lo));
            chk($sformatf("v%0d_err_cnt", i),   32'(err_cnt),   32'(cnt_exp(tbl[i].exp_cnt)));
        end

        // async reset while FULL: outputs clear without a clock edge
        req = 4'b1000; req_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("full_out_valid", 32'(out_valid), 1);
        chk("full_code",      32'(code), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_code",      32'(code), 0);
        chk("mid_rst_err_cnt",   32'(err_cnt), 0);
        chk("mid_rst_err_cnt_lo", 32'(err_cnt_lo), 0);
        chk("mid_rst_in_ready",  32'(in_ready), 1);
        @(posedge clk); #1;
        chk("held_rst_out_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("post_rst_in_ready",  32'(in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
